tlcd_bus_arbiter: RTL and testbench
===================================

Name: tlcd_bus_arbiter

Overview:
- Shares the single character-LCD write bus between two requesters and sequences every byte write with correct E/RS/RW timing.
- Requester 0 is the custom-font loader; requester 1 is the text controller.
- Replaces the static done-based output mux, so both requesters can interleave writes, e.g. font reloads mid-game.
- Sits between the LCD requesters and the TLCD_* top-level pins; runs on the 1 MHz system clock.

Parameters:
SETUP_CYC, 1, cycles RS/DATA are stable before E rises (min 1)
E_HIGH_CYC, 1, cycles E is held high (min 1)
HOLD_CYC, 1, cycles RS/DATA are held after E falls (min 1)
EXEC_CYC, 40, post-write busy wait for normal commands and data (≥37 us at 1 MHz)
LONG_EXEC_CYC, 1600, post-write busy wait for clear/home commands (≥1.52 ms)

Ports:
CLK  in  1  system clock, 1 MHz
RST  in  1  asynchronous active-high reset
REQ0  in  1  requester 0 write request; held until ACK0
RS0  in  1  requester 0 register select (0 = command, 1 = data)
DATA0  in  8  requester 0 byte
ACK0  out  1  one-cycle completion pulse to requester 0
REQ1  in  1  requester 1 write request; held until ACK1
RS1  in  1  requester 1 register select
DATA1  in  8  requester 1 byte
ACK1  out  1  one-cycle completion pulse to requester 1
BUSY  out  1  high while a transaction is in progress, including the ACK cycle
GNT_ID  out  1  owner of the current or last transaction
TLCD_E  out  1  LCD enable strobe
TLCD_RS  out  1  LCD register select
TLCD_RW  out  1  LCD read/write; tied 0 (write only)
TLCD_DATA  out  8  LCD data bus

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: all outputs 0. State IDLE. Last-grant pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT, ACK.
  - A single counter, at least 11 bits, times each phase.
  - SETUP, PULSE, HOLD and WAIT each last exactly their parameter count.
- IDLE: REQx is sampled only in this state.
  - On the capturing edge: latch RS/DATA from the winner, set GNT_ID, set BUSY=1, go to SETUP.
  - Only one REQ high: grant it.
  - Both high: grant the requester not granted last (round robin).
- SETUP: TLCD_RS and TLCD_DATA drive the latched values; E=0.
- PULSE: E=1.
- HOLD: E=0; RS and DATA unchanged.
- WAIT: E=0; wait length is chosen at latch time.
  - Long wait (LONG_EXEC_CYC) when RS=0 and DATA ∈ {0x01, 0x02, 0x03}.
  - Short wait (EXEC_CYC) otherwise, including RS=0 with DATA=0x00.
- ACK: one cycle; ACKx for the granted requester =1; BUSY still 1. Next state is IDLE, where BUSY returns to 0.
- Latency:
  - ACK is high exactly SETUP_CYC+E_HIGH_CYC+HOLD_CYC+EXEC cycles after the BUSY rising edge.
  - Defaults: 43 cycles short, 1603 cycles long.
  - Minimum back-to-back period is that value +2 cycles (ACK cycle + IDLE cycle).
- TLCD_RS and TLCD_DATA keep the last latched values between transactions; they do not glitch in IDLE.
- Requester rules:
  - Requester must drop REQ on the edge at which it sees ACK. If REQ is still high in IDLE, a new write is started with the current data.
  - REQ or data changes after the latch edge are ignored. The transaction completes and ACK is still issued even if REQ dropped early.
- TLCD_E is never high outside PULSE. ACK0 and ACK1 are never high together.
- Reset mid-transaction: outputs return to reset values immediately and the transaction is abandoned with no ACK. After release, the first tie goes to requester 0.

Test Plan:
- Reset, then REQ1=1, RS1=1, DATA1=0x41:
  - BUSY rises next edge; E high for exactly 1 cycle, 1 cycle after BUSY rises.
  - TLCD_DATA=0x41 and TLCD_RS=1 from SETUP onward; ACK1 pulses 43 cycles after BUSY rises; ACK0 stays 0.
- REQ0 with RS0=0, DATA0=0x01: long wait, ACK0 at 1603 cycles. Repeat with DATA0=0x00 and with RS0=1, DATA0=0x01: ACK at 43 cycles.
- REQ0 and REQ1 both held continuously, each dropped one cycle on its ACK:
  - Grants alternate 0,1,0,1 starting with 0; GNT_ID matches.
  - Spacing between successive BUSY rising edges is 45 cycles.
- Change DATA1 from 0x41 to 0x5A and drop REQ1 two cycles after latch: TLCD_DATA stays 0x41, and ACK1 still pulses at cycle 43.
- Assert RST during WAIT: E, RS, DATA, BUSY, ACK go to 0 asynchronously with no ACK. After release with both REQs high, requester 0 is granted first.
- Over every run, assert E only during PULSE, TLCD_RW ≡ 0, never ACK0&ACK1, and RS/DATA stable from SETUP through HOLD.

Source files
------------

// File: rtl/tlcd_bus_arbiter_if.sv
// Bus bundle between the two LCD requesters, the arbiter and the TLCD_* pins.
// master = requester/pin side, slave = arbiter.
interface tlcd_bus_arbiter_if;
  logic       REQ0;
  logic       RS0;
  logic [7:0] DATA0;
  logic       ACK0;
  logic       REQ1;
  logic       RS1;
  logic [7:0] DATA1;
  logic       ACK1;
  logic       BUSY;
  logic       GNT_ID;
  logic       TLCD_E;
  logic       TLCD_RS;
  logic       TLCD_RW;
  logic [7:0] TLCD_DATA;

  modport master (
    output REQ0, RS0, DATA0, REQ1, RS1, DATA1,
    input  ACK0, ACK1, BUSY, GNT_ID, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA
  );

  modport slave (
    input  REQ0, RS0, DATA0, REQ1, RS1, DATA1,
    output ACK0, ACK1, BUSY, GNT_ID, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA
  );
endinterface

// File: rtl/tlcd_bus_arbiter.sv
// Round-robin arbiter for the character-LCD write bus: grants one of two requesters
// and sequences SETUP / E pulse / HOLD / busy-wait / ACK for each byte.
module tlcd_bus_arbiter #(
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned E_HIGH_CYC    = 1,
  parameter int unsigned HOLD_CYC      = 1,
  parameter int unsigned EXEC_CYC      = 40,
  parameter int unsigned LONG_EXEC_CYC = 1600
) (
  input  logic                CLK,
  input  logic                RST,
  tlcd_bus_arbiter_if.slave   bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCyc =
      max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(HOLD_CYC, EXEC_CYC)), LONG_EXEC_CYC);
  localparam int unsigned CntW = max2($clog2(MaxCyc + 1), 11);

  // Counters are loaded with length-1 and the phase ends when they reach zero.
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] EHighLd = CntW'(E_HIGH_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] ExecLd  = CntW'(EXEC_CYC - 1);
  localparam logic [CntW-1:0] LongLd  = CntW'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            long_q, long_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;

  logic            grant;
  logic            win_rs;
  logic [7:0]      win_data;
  logic            cnt_done;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant    = bus.REQ1 & (~bus.REQ0 | ~last_q);
  assign win_rs   = grant ? bus.RS1 : bus.RS0;
  assign win_data = grant ? bus.DATA1 : bus.DATA0;
  assign cnt_done = (cnt_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ0 || bus.REQ1) begin
          rs_d    = win_rs;
          data_d  = win_data;
          // Clear display / return home need the long execution time.
          long_d  = ~win_rs && (win_data == 8'h01 || win_data == 8'h02 ||
                                win_data == 8'h03);
          gnt_d   = grant;
          last_d  = grant;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_done) begin
          cnt_d   = EHighLd;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_done) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_done) begin
          cnt_d   = long_q ? LongLd : ExecLd;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWait: begin
        if (cnt_done) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.BUSY      = (state_q != StIdle);
    bus.TLCD_E    = (state_q == StPulse);
    bus.ACK0      = (state_q == StAck) && !gnt_q;
    bus.ACK1      = (state_q == StAck) && gnt_q;
    bus.GNT_ID    = gnt_q;
    bus.TLCD_RS   = rs_q;
    bus.TLCD_DATA = data_q;
    bus.TLCD_RW   = 1'b0;
  end

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// Directed bench for tlcd_bus_arbiter: latency, long/short waits, round robin,
// late data changes and mid-transaction reset, plus continuous bus invariants.
module tb_tlcd_bus_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  tlcd_bus_arbiter_if bus ();

  tlcd_bus_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Returns ticks until the chosen ACK is seen; 3000 means it never came.
  task automatic wait_ack(input bit which, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(which ? bus.ACK1 : bus.ACK0) && n < 3000);
  endtask

  // Invariants sampled on the falling edge: E only in the cycle after BUSY rises,
  // RW low, ACKs exclusive, RS/DATA frozen for the whole transaction.
  bit         busy_prev = 1'b0;
  int         bcyc      = 0;
  logic       mon_rs;
  logic [7:0] mon_data;

  always @(negedge CLK) begin
    if (!RST && bus.BUSY) begin
      if (!busy_prev) begin
        bcyc     = 0;
        mon_rs   = bus.TLCD_RS;
        mon_data = bus.TLCD_DATA;
      end else begin
        bcyc++;
        check("mon_rs_stable", 32'(bus.TLCD_RS), 32'(mon_rs));
        check("mon_data_stable", 32'(bus.TLCD_DATA), 32'(mon_data));
      end
    end
    check("mon_e", 32'(bus.TLCD_E), 32'(!RST && bus.BUSY && bcyc == 1));
    check("mon_rw", 32'(bus.TLCD_RW), 32'd0);
    check("mon_ack_excl", 32'(bus.ACK0 & bus.ACK1), 32'd0);
    busy_prev = !RST && bus.BUSY;
  end

  logic [7:0] t2_data [3] = '{8'h01, 8'h00, 8'h01};
  bit         t2_rs   [3] = '{1'b0, 1'b0, 1'b1};
  int         t2_lat  [3] = '{1603, 43, 43};

  initial begin
    int  n;
    int  last_rise;
    bit  g;

    RST       = 1'b1;
    bus.REQ0  = 1'b0;
    bus.RS0   = 1'b0;
    bus.DATA0 = 8'h00;
    bus.REQ1  = 1'b0;
    bus.RS1   = 1'b0;
    bus.DATA1 = 8'h00;
    last_rise = 0;
    tick();
    tick();

    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_e", 32'(bus.TLCD_E), 32'd0);
    check("rst_rs", 32'(bus.TLCD_RS), 32'd0);
    check("rst_data", 32'(bus.TLCD_DATA), 32'd0);
    check("rst_ack0", 32'(bus.ACK0), 32'd0);
    check("rst_ack1", 32'(bus.ACK1), 32'd0);
    check("rst_gnt", 32'(bus.GNT_ID), 32'd0);
    RST = 1'b0;

    // Single data write from requester 1.
    bus.REQ1  = 1'b1;
    bus.RS1   = 1'b1;
    bus.DATA1 = 8'h41;
    tick();
    check("t1_busy", 32'(bus.BUSY), 32'd1);
    check("t1_gnt", 32'(bus.GNT_ID), 32'd1);
    check("t1_rs", 32'(bus.TLCD_RS), 32'd1);
    check("t1_data", 32'(bus.TLCD_DATA), 32'h41);
    check("t1_e_setup", 32'(bus.TLCD_E), 32'd0);
    tick();
    check("t1_e_pulse", 32'(bus.TLCD_E), 32'd1);
    wait_ack(1'b1, n);
    check("t1_lat", 32'(n + 1), 32'd43);
    check("t1_ack0", 32'(bus.ACK0), 32'd0);
    check("t1_busy_ack", 32'(bus.BUSY), 32'd1);
    bus.REQ1 = 1'b0;
    tick();
    check("t1_idle_busy", 32'(bus.BUSY), 32'd0);
    check("t1_idle_ack1", 32'(bus.ACK1), 32'd0);
    check("t1_idle_data", 32'(bus.TLCD_DATA), 32'h41);
    check("t1_idle_rs", 32'(bus.TLCD_RS), 32'd1);

    // Requester 0: clear (long), NOP-ish 0x00 command (short), data 0x01 (short).
    for (int i = 0; i < 3; i++) begin
      bus.REQ0  = 1'b1;
      bus.RS0   = t2_rs[i];
      bus.DATA0 = t2_data[i];
      tick();
      check("t2_busy", 32'(bus.BUSY), 32'd1);
      check("t2_gnt", 32'(bus.GNT_ID), 32'd0);
      wait_ack(1'b0, n);
      check("t2_lat", 32'(n), 32'(t2_lat[i]));
      check("t2_ack1", 32'(bus.ACK1), 32'd0);
      bus.REQ0 = 1'b0;
      tick();
    end

    // Late data change and early REQ drop are ignored.
    bus.REQ1  = 1'b1;
    bus.RS1   = 1'b1;
    bus.DATA1 = 8'h41;
    tick();
    check("t4_busy", 32'(bus.BUSY), 32'd1);
    tick();
    tick();
    bus.DATA1 = 8'h5A;
    bus.REQ1  = 1'b0;
    wait_ack(1'b1, n);
    check("t4_lat", 32'(n + 2), 32'd43);
    check("t4_data", 32'(bus.TLCD_DATA), 32'h41);
    tick();
    tick();
    check("t4_no_restart", 32'(bus.BUSY), 32'd0);
    check("t4_data_idle", 32'(bus.TLCD_DATA), 32'h41);

    // Both requesters held: grants alternate starting with 0, rises 45 apart.
    bus.REQ0  = 1'b1;
    bus.RS0   = 1'b1;
    bus.DATA0 = 8'h30;
    bus.REQ1  = 1'b1;
    bus.RS1   = 1'b1;
    bus.DATA1 = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      tick();
      check("t3_busy", 32'(bus.BUSY), 32'd1);
      check("t3_gnt", 32'(bus.GNT_ID), 32'(g));
      check("t3_data", 32'(bus.TLCD_DATA), g ? 32'h5A : 32'h30);
      if (k > 0) check("t3_spacing", 32'(cyc - last_rise), 32'd45);
      last_rise = cyc;
      wait_ack(g, n);
      check("t3_lat", 32'(n), 32'd43);
      if (g) bus.REQ1 = 1'b0;
      else   bus.REQ0 = 1'b0;
      tick();
      if (g) bus.REQ1 = 1'b1;
      else   bus.REQ0 = 1'b1;
    end

    // Reset in the middle of WAIT, then tie must go to requester 0 again.
    tick();
    check("t5_busy", 32'(bus.BUSY), 32'd1);
    check("t5_gnt", 32'(bus.GNT_ID), 32'd0);
    repeat (10) tick();
    #2;
    RST = 1'b1;
    #1;
    check("t5_rst_busy", 32'(bus.BUSY), 32'd0);
    check("t5_rst_e", 32'(bus.TLCD_E), 32'd0);
    check("t5_rst_rs", 32'(bus.TLCD_RS), 32'd0);
    check("t5_rst_data", 32'(bus.TLCD_DATA), 32'd0);
    check("t5_rst_ack", 32'({bus.ACK0, bus.ACK1}), 32'd0);
    check("t5_rst_gnt", 32'(bus.GNT_ID), 32'd0);
    tick();
    tick();
    check("t5_held_ack", 32'({bus.ACK0, bus.ACK1}), 32'd0);
    RST = 1'b0;
    tick();
    check("t5_rel_busy", 32'(bus.BUSY), 32'd1);
    check("t5_rel_gnt", 32'(bus.GNT_ID), 32'd0);
    check("t5_rel_data", 32'(bus.TLCD_DATA), 32'h30);
    wait_ack(1'b0, n);
    check("t5_lat", 32'(n), 32'd43);
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
